// File: rtl/ahb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_if
// Bundles the request, transfer-control and grant signals shared between the
// bus masters and the two-master AHB arbiter.
//   hbusreq_1/2, hlock_1/2 : per-master bus request and locked-transfer request
//   htrans, hburst, hready : multiplexed transfer type, burst type and ready of
//                            the current bus owner
//   hgrant_1/2             : one-hot (or all-zero) grants from the arbiter
//   hmaster                : address-phase owner number (0 none, 1, 2)
//   hmaster_data           : data-phase owner number
//   hmastlock              : lock of the address-phase owner
// Modports: master = bus/master side (drives requests, sees grants),
//           slave  = arbiter side (sees requests, drives grants).
// ---------------------------------------------------------------------------
interface ahb_arbiter_if;
    logic       hbusreq_1;
    logic       hbusreq_2;
    logic       hlock_1;
    logic       hlock_2;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic       hgrant_1;
    logic       hgrant_2;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    modport master (
        output hbusreq_1, hbusreq_2, hlock_1, hlock_2, htrans, hburst, hready,
        input  hgrant_1, hgrant_2, hmaster, hmaster_data, hmastlock
    );

    modport slave (
        input  hbusreq_1, hbusreq_2, hlock_1, hlock_2, htrans, hburst, hready,
        output hgrant_1, hgrant_2, hmaster, hmaster_data, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Two-master AHB bus arbiter. Grants the bus to master 1 or 2 and only moves
// ownership at legal arbitration points: never inside a fixed-length burst
// and never while the owner holds a locked sequence.
//   hclk   : bus clock, all state updates on the rising edge
//   hreset : synchronous active-high reset
//   bus    : ahb_arbiter_if.slave (requests/locks/htrans/hburst/hready in,
//            hgrant_1/2, hmaster, hmaster_data, hmastlock out)
// Parameter RR_MODE: 1 = round-robin on contention, 0 = master 1 always wins.
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int RR_MODE = 1
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN1 = 2'b01,
        ST_OWN2 = 2'b10
    } state_e;

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // Number of SEQ beats that follow the NONSEQ beat of a burst.
    // SINGLE and undefined-length INCR leave nothing pending.
    function automatic logic [3:0] burst_remaining(input logic [2:0] burst);
        logic [3:0] rem;
        case (burst)
            3'b000, 3'b001: rem = 4'd0;
            3'b010, 3'b011: rem = 4'd3;
            3'b100, 3'b101: rem = 4'd7;
            3'b110, 3'b111: rem = 4'd15;
            default:        rem = 4'd0;
        endcase
        return rem;
    endfunction

    state_e     state_r;
    logic [3:0] beat_cnt_r;
    logic [1:0] last_owner_r;
    logic       hgrant_1_r;
    logic       hgrant_2_r;
    logic [1:0] hmaster_data_r;
    logic       hmastlock_r;

    logic [3:0] next_cnt_s;
    logic       owner_locked_s;
    logic       arb_point_s;
    state_e     winner_s;
    state_e     next_state_s;
    logic       next_lock_s;
    logic [1:0] hmaster_s;

    // Address-phase owner decoded straight from the registered grants.
    always_comb begin
        hmaster_s = 2'd0;
        if (hgrant_1_r) begin
            hmaster_s = 2'd1;
        end else if (hgrant_2_r) begin
            hmaster_s = 2'd2;
        end else begin
            hmaster_s = 2'd0;
        end
    end

    // Beat counter next value: only accepted address phases advance it;
    // BUSY/IDLE and early termination leave it untouched.
    always_comb begin
        next_cnt_s = beat_cnt_r;
        if (bus.hready) begin
            case (bus.htrans)
                TR_NONSEQ: next_cnt_s = burst_remaining(bus.hburst);
                TR_SEQ: begin
                    if (beat_cnt_r != 4'd0) begin
                        next_cnt_s = beat_cnt_r - 4'd1;
                    end else begin
                        next_cnt_s = beat_cnt_r;
                    end
                end
                default:   next_cnt_s = beat_cnt_r;
            endcase
        end else begin
            next_cnt_s = beat_cnt_r;
        end
    end

    // A lock only counts while the owner is also still requesting.
    always_comb begin
        owner_locked_s = 1'b0;
        case (state_r)
            ST_OWN1: owner_locked_s = bus.hlock_1 & bus.hbusreq_1;
            ST_OWN2: owner_locked_s = bus.hlock_2 & bus.hbusreq_2;
            default: owner_locked_s = 1'b0;
        endcase
    end

    // Arbitration point. With no grant the downstream mux holds hready low,
    // so IDLE arbitrates every cycle instead of waiting for it. An illegal
    // encoding also arbitrates so the FSM recovers on its own.
    always_comb begin
        arb_point_s = 1'b1;
        case (state_r)
            ST_IDLE: arb_point_s = 1'b1;
            ST_OWN1, ST_OWN2:
                arb_point_s = bus.hready & (next_cnt_s == 4'd0) & ~owner_locked_s;
            default: arb_point_s = 1'b1;
        endcase
    end

    // Winner selection; on contention round-robin hands the bus to the master
    // that does not currently own it (from IDLE: the one that did not own last).
    always_comb begin
        winner_s = ST_IDLE;
        case ({bus.hbusreq_1, bus.hbusreq_2})
            2'b10: winner_s = ST_OWN1;
            2'b01: winner_s = ST_OWN2;
            2'b11: begin
                if (RR_MODE == 0) begin
                    winner_s = ST_OWN1;
                end else begin
                    case (state_r)
                        ST_OWN1: winner_s = ST_OWN2;
                        ST_OWN2: winner_s = ST_OWN1;
                        default: winner_s = (last_owner_r == 2'd1) ? ST_OWN2 : ST_OWN1;
                    endcase
                end
            end
            default: winner_s = ST_IDLE;
        endcase
    end

    // Next owner and the lock that owner presents.
    always_comb begin
        next_state_s = state_r;
        next_lock_s  = 1'b0;
        if (arb_point_s) begin
            next_state_s = winner_s;
        end else begin
            next_state_s = state_r;
        end
        case (next_state_s)
            ST_OWN1: next_lock_s = bus.hlock_1;
            ST_OWN2: next_lock_s = bus.hlock_2;
            default: next_lock_s = 1'b0;
        endcase
    end

    // Arbiter state, grants and phase-tracking registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r        <= ST_IDLE;
            beat_cnt_r     <= 4'd0;
            last_owner_r   <= 2'd2;
            hgrant_1_r     <= 1'b0;
            hgrant_2_r     <= 1'b0;
            hmaster_data_r <= 2'd0;
            hmastlock_r    <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            beat_cnt_r <= next_cnt_s;
            hgrant_1_r <= (next_state_s == ST_OWN1);
            hgrant_2_r <= (next_state_s == ST_OWN2);
            if ((next_state_s != state_r) && (next_state_s != ST_IDLE)) begin
                last_owner_r <= (next_state_s == ST_OWN1) ? 2'd1 : 2'd2;
            end
            // Data phase follows the address phase that was just accepted.
            if (bus.hready) begin
                hmaster_data_r <= hmaster_s;
            end
            if (bus.hready || (state_r == ST_IDLE)) begin
                hmastlock_r <= next_lock_s;
            end
        end
    end

    assign bus.hgrant_1     = hgrant_1_r;
    assign bus.hgrant_2     = hgrant_2_r;
    assign bus.hmaster      = hmaster_s;
    assign bus.hmaster_data = hmaster_data_r;
    assign bus.hmastlock    = hmastlock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
// Drives a round-robin and a fixed-priority arbiter with identical stimulus
// and compares both against a cycle-level behavioural model of ownership,
// remaining burst beats, data-phase owner and lock.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    logic       hclk = 1'b0;
    logic       hreset;
    logic       hbusreq_1, hbusreq_2, hlock_1, hlock_2;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    int m_own[2];
    int m_cnt[2];
    int m_last[2];
    int m_dat[2];
    int m_lck[2];

    ahb_arbiter_if if_fp();
    ahb_arbiter_if if_rr();

    assign if_fp.hbusreq_1 = hbusreq_1;
    assign if_fp.hbusreq_2 = hbusreq_2;
    assign if_fp.hlock_1   = hlock_1;
    assign if_fp.hlock_2   = hlock_2;
    assign if_fp.htrans    = htrans;
    assign if_fp.hburst    = hburst;
    assign if_fp.hready    = hready;
    assign if_rr.hbusreq_1 = hbusreq_1;
    assign if_rr.hbusreq_2 = hbusreq_2;
    assign if_rr.hlock_1   = hlock_1;
    assign if_rr.hlock_2   = hlock_2;
    assign if_rr.htrans    = htrans;
    assign if_rr.hburst    = hburst;
    assign if_rr.hready    = hready;

    ahb_arbiter #(.RR_MODE(0)) u_fp (.hclk(hclk), .hreset(hreset), .bus(if_fp));
    ahb_arbiter #(.RR_MODE(1)) u_rr (.hclk(hclk), .hreset(hreset), .bus(if_rr));

    always #5 hclk = ~hclk;

    function automatic logic [6:0] obs_vec(input int m);
        if (m == 0)
            return {if_fp.hgrant_1, if_fp.hgrant_2, if_fp.hmaster, if_fp.hmaster_data, if_fp.hmastlock};
        else
            return {if_rr.hgrant_1, if_rr.hgrant_2, if_rr.hmaster, if_rr.hmaster_data, if_rr.hmastlock};
    endfunction

    function automatic logic [6:0] exp_vec(input int m);
        logic [1:0] o;
        logic [1:0] d;
        o = 2'(m_own[m]);
        d = 2'(m_dat[m]);
        return {m_own[m] == 1, m_own[m] == 2, o, d, m_lck[m] != 0};
    endfunction

    // One clock of the reference: ownership moves only when the burst has no
    // beats left after this accepted phase and the owner is not locked.
    task automatic model_step(input int m);
        int nxt;
        int beats;
        int own_new;
        bit locked;
        if (hreset) begin
            m_own[m] = 0; m_cnt[m] = 0; m_last[m] = 2; m_dat[m] = 0; m_lck[m] = 0;
        end else begin
            nxt = m_cnt[m];
            if (hready && htrans == 2'b10) begin
                beats = (hburst < 3'd2) ? 1 : (2 << int'(hburst / 3'd2));
                nxt = beats - 1;
            end else if (hready && htrans == 2'b11 && nxt > 0) begin
                nxt = nxt - 1;
            end
            locked = (m_own[m] == 1 && hlock_1 && hbusreq_1) ||
                     (m_own[m] == 2 && hlock_2 && hbusreq_2);
            own_new = m_own[m];
            if (m_own[m] == 0 || (hready && nxt == 0 && !locked)) begin
                if (hbusreq_1 && hbusreq_2)
                    own_new = (m == 0) ? 1 : 3 - ((m_own[m] != 0) ? m_own[m] : m_last[m]);
                else if (hbusreq_1) own_new = 1;
                else if (hbusreq_2) own_new = 2;
                else                own_new = 0;
            end
            if (own_new != m_own[m] && own_new != 0) m_last[m] = own_new;
            if (hready) m_dat[m] = m_own[m];
            if (hready || m_own[m] == 0)
                m_lck[m] = (own_new == 1) ? int'(hlock_1) : (own_new == 2) ? int'(hlock_2) : 0;
            m_own[m] = own_new;
            m_cnt[m] = nxt;
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic drive(input logic b1, input logic b2, input logic l1, input logic l2,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        hbusreq_1 = b1; hbusreq_2 = b2; hlock_1 = l1; hlock_2 = l2;
        htrans = tr; hburst = bu; hready = rdy;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (obs_vec(m) !== 7'd0) begin
                n_err++;
                $display("FAIL reset mode%0d: got %b want %b", m, obs_vec(m), 7'd0);
            end
            n_vec++;
            if (obs_vec(m) !== exp_vec(m)) begin
                n_err++;
                $display("FAIL reset_model mode%0d: got %b want %b", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_single_grant();
        hreset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);
        tick();
        n_vec++;
        if (if_rr.hgrant_1 !== 1'b1 || if_rr.hmaster !== 2'd1 || if_rr.hmaster_data !== 2'd0) begin
            n_err++;
            $display("FAIL first_grant: got g1=%b hmaster=%0d hdata=%0d want g1=1 hmaster=1 hdata=0",
                     if_rr.hgrant_1, if_rr.hmaster, if_rr.hmaster_data);
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (obs_vec(m) !== exp_vec(m) || obs_vec(m) !== 7'b1001010) begin
                n_err++;
                $display("FAIL data_owner mode%0d: got %b want %b", m, obs_vec(m), 7'b1001010);
            end
        end
    endtask

    task automatic test_incr4_handover();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 3'b011, 1'b1);
        for (int beat = 1; beat <= 4; beat++) begin
            tick();
            htrans = 2'b11;
            for (int m = 0; m < 2; m++) begin
                n_vec++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL incr4 beat%0d mode%0d: got %b want %b", beat, m, obs_vec(m), exp_vec(m));
                end
            end
            n_vec++;
            if (if_rr.hmaster !== ((beat < 4) ? 2'd1 : 2'd2) || if_fp.hmaster !== 2'd1) begin
                n_err++;
                $display("FAIL incr4_owner beat%0d: got rr=%0d fp=%0d want rr=%0d fp=1",
                         beat, if_rr.hmaster, if_fp.hmaster, (beat < 4) ? 1 : 2);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
        n_vec++;
        if (if_rr.hgrant_1 !== 1'b1 || if_rr.hmaster_data !== 2'd1) begin
            n_err++;
            $display("FAIL incr4_return: got g1=%b hdata=%0d want 1 1", if_rr.hgrant_1, if_rr.hmaster_data);
        end
    endtask

    task automatic test_wait_states();
        logic [1:0] want;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 3'b010, 1'b1);
        for (int i = 0; i < 6; i++) begin
            htrans = (i == 0) ? 2'b10 : 2'b11;
            hready = !(i == 2 || i == 3);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_vec++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL wait cyc%0d mode%0d: got %b want %b", i, m, obs_vec(m), exp_vec(m));
                end
            end
            want = (i < 5) ? 2'd1 : 2'd2;
            n_vec++;
            if (if_rr.hmaster !== want || if_rr.hmaster_data !== 2'd1) begin
                n_err++;
                $display("FAIL wait_owner cyc%0d: got hmaster=%0d hdata=%0d want %0d 1",
                         i, if_rr.hmaster, if_rr.hmaster_data, want);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                n_vec++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL rr cyc%0d mode%0d: got %b want %b", i, m, obs_vec(m), exp_vec(m));
                end
            end
            n_vec++;
            if (if_rr.hmaster !== ((i % 2 == 0) ? 2'd1 : 2'd2) || if_fp.hgrant_1 !== 1'b1) begin
                n_err++;
                $display("FAIL alternate cyc%0d: got rr=%0d fp_g1=%b want rr=%0d fp_g1=1",
                         i, if_rr.hmaster, if_fp.hgrant_1, (i % 2 == 0) ? 1 : 2);
            end
        end
    endtask

    task automatic test_lock();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                n_vec++;
                if (obs_vec(m) !== exp_vec(m) || obs_vec(m) !== 7'b0110101) begin
                    n_err++;
                    $display("FAIL locked cyc%0d mode%0d: got %b want %b", i, m, obs_vec(m), 7'b0110101);
                end
            end
        end
        hlock_2 = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (obs_vec(m) !== exp_vec(m) || obs_vec(m) !== 7'b1001100) begin
                n_err++;
                $display("FAIL unlock mode%0d: got %b want %b", m, obs_vec(m), 7'b1001100);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b101, 1'b1);
        tick();
        htrans = 2'b11;
        tick();
        tick();
        hreset = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (obs_vec(m) !== 7'd0 || obs_vec(m) !== exp_vec(m)) begin
                n_err++;
                $display("FAIL mid_reset mode%0d: got %b want %b", m, obs_vec(m), 7'd0);
            end
        end
        hreset = 1'b0;
        htrans = 2'b00;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (obs_vec(m) !== exp_vec(m) || obs_vec(m) !== 7'b1001000) begin
                n_err++;
                $display("FAIL regrant mode%0d: got %b want %b", m, obs_vec(m), 7'b1001000);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            hreset    = ($urandom_range(0, 63) == 0);
            hbusreq_1 = ($urandom_range(0, 3) != 0);
            hbusreq_2 = ($urandom_range(0, 3) != 0);
            hlock_1   = ($urandom_range(0, 5) == 0);
            hlock_2   = ($urandom_range(0, 5) == 0);
            htrans    = 2'($urandom_range(0, 3));
            hburst    = 3'($urandom_range(0, 7));
            hready    = ($urandom_range(0, 3) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                n_vec++;
                if (obs_vec(m) !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL random cyc%0d mode%0d: got %b want %b", i, m, obs_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_incr4_handover();
        test_wait_states();
        test_round_robin();
        test_lock();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1);
    end

endmodule
